// File: rtl/ov5640_cfg_ctrl_if.sv
// Write-request bus between the OV5640 configuration controller and the SCCB master.
interface ov5640_cfg_ctrl_if;
    logic        sccb_req;
    logic [15:0] sccb_addr;
    logic [7:0]  sccb_wdata;
    logic        sccb_done;
    logic        sccb_nack;

    modport master (
        output sccb_req, sccb_addr, sccb_wdata,
        input  sccb_done, sccb_nack
    );

    modport slave (
        input  sccb_req, sccb_addr, sccb_wdata,
        output sccb_done, sccb_nack
    );
endinterface

// File: rtl/ov5640_cfg_ctrl.sv
// OV5640 power-up sequencer: drives PWDN/RESETB timing, then writes a ROM register
// table through the SCCB master with bounded retry on NACK.
module ov5640_cfg_ctrl #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned T_PWDN_MS = 5,
    parameter int unsigned T_RST_MS  = 1,
    parameter int unsigned T_INIT_MS = 20,
    parameter int unsigned REG_NUM   = 250,
    parameter int unsigned ROM_AW    = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cfg_start,
    output logic                  cam_pwdn,
    output logic                  cam_reset,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [23:0]           rom_data,
    ov5640_cfg_ctrl_if.master     sccb,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err
);

    localparam int unsigned DIV     = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
    localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned MS_W    = 16;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // S_LOAD covers the ROM read latency; S_ISSUE latches the entry and raises the request.
    // S_RETRY is the one idle cycle between a NACKed attempt and its reissue.
    typedef enum logic [3:0] {
        S_PWDN,
        S_RST,
        S_INIT,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_RETRY,
        S_DONE,
        S_ERR
    } state_t;

    state_t               state, state_d;
    logic [PRESC_W-1:0]   presc, presc_d;
    logic [MS_W-1:0]      ms_cnt, ms_d;
    logic [RETRY_W-1:0]   retry, retry_d;
    logic [ROM_AW-1:0]    rom_addr_d;
    logic                 req_d;
    logic [15:0]          addr_d;
    logic [7:0]           wdata_d;
    logic                 pwdn_d, reset_d, done_d, err_d, busy_d;
    logic                 tick_c;

    // Next-state, timer and output computation
    always_comb begin
        state_d    = state;
        presc_d    = presc;
        ms_d       = ms_cnt;
        retry_d    = retry;
        rom_addr_d = rom_addr;
        req_d      = sccb.sccb_req;
        addr_d     = sccb.sccb_addr;
        wdata_d    = sccb.sccb_wdata;
        pwdn_d     = cam_pwdn;
        reset_d    = cam_reset;
        done_d     = cfg_done;
        err_d      = cfg_err;
        busy_d     = cfg_busy;

        tick_c = (presc == PRESC_W'(DIV - 1));
        if (tick_c) begin
            presc_d = '0;
            ms_d    = ms_cnt + 1'b1;
        end else begin
            presc_d = presc + 1'b1;
        end

        case (state)
            S_PWDN: begin
                if (tick_c && ms_cnt == MS_W'(T_PWDN_MS - 1)) begin
                    state_d = S_RST;
                    pwdn_d  = 1'b0;
                    reset_d = 1'b0;
                end
            end
            S_RST: begin
                if (tick_c && ms_cnt == MS_W'(T_RST_MS - 1)) begin
                    state_d = S_INIT;
                    reset_d = 1'b1;
                end
            end
            S_INIT: begin
                if (tick_c && ms_cnt == MS_W'(T_INIT_MS - 1)) begin
                    state_d    = S_LOAD;
                    rom_addr_d = '0;
                end
            end
            S_LOAD: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                addr_d  = rom_data[23:8];
                wdata_d = rom_data[7:0];
                req_d   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sccb.sccb_done) begin
                    req_d = 1'b0;
                    if (!sccb.sccb_nack) begin
                        retry_d = '0;
                        if (rom_addr == ROM_AW'(REG_NUM - 1)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            rom_addr_d = rom_addr + 1'b1;
                            state_d    = S_LOAD;
                        end
                    end else if (retry < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry + 1'b1;
                        state_d = S_RETRY;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RETRY: begin
                req_d   = 1'b1;
                state_d = S_WAIT;
            end
            S_DONE, S_ERR: begin
                if (cfg_start) begin
                    state_d    = S_PWDN;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    retry_d    = '0;
                    rom_addr_d = '0;
                    pwdn_d     = 1'b1;
                    reset_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_PWDN;
                pwdn_d  = 1'b1;
                reset_d = 1'b0;
                req_d   = 1'b0;
            end
        endcase

        // Every state starts with a fresh ms count
        if (state_d != state) begin
            presc_d = '0;
            ms_d    = '0;
        end

        busy_d = !(state_d == S_DONE || state_d == S_ERR);
    end

    // State and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state           <= S_PWDN;
            presc           <= '0;
            ms_cnt          <= '0;
            retry           <= '0;
            rom_addr        <= '0;
            sccb.sccb_req   <= 1'b0;
            sccb.sccb_addr  <= '0;
            sccb.sccb_wdata <= '0;
            cam_pwdn        <= 1'b1;
            cam_reset       <= 1'b0;
            cfg_done        <= 1'b0;
            cfg_err         <= 1'b0;
            cfg_busy        <= 1'b1;
        end else begin
            state           <= state_d;
            presc           <= presc_d;
            ms_cnt          <= ms_d;
            retry           <= retry_d;
            rom_addr        <= rom_addr_d;
            sccb.sccb_req   <= req_d;
            sccb.sccb_addr  <= addr_d;
            sccb.sccb_wdata <= wdata_d;
            cam_pwdn        <= pwdn_d;
            cam_reset       <= reset_d;
            cfg_done        <= done_d;
            cfg_err         <= err_d;
            cfg_busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_ov5640_cfg_ctrl.sv
// Directed bench for ov5640_cfg_ctrl: power-up timing, table walk, NACK retry/fail,
// cfg_start handling and reset during a transfer.
module tb_ov5640_cfg_ctrl;

    localparam int unsigned REG_NUM = 4;
    localparam int unsigned ROM_AW  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic              cam_pwdn, cam_reset;
    logic [ROM_AW-1:0] rom_addr;
    logic [23:0]       rom_data;
    logic              cfg_busy, cfg_done, cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    ov5640_cfg_ctrl_if bus ();

    ov5640_cfg_ctrl #(
        .CLK_FREQ (10_000),
        .T_PWDN_MS(5),
        .T_RST_MS (1),
        .T_INIT_MS(20),
        .REG_NUM  (REG_NUM),
        .ROM_AW   (ROM_AW),
        .MAX_RETRY(3)
    ) dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .cfg_start(cfg_start),
        .cam_pwdn (cam_pwdn),
        .cam_reset(cam_reset),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sccb     (bus.master),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] addr_of(input int i);
        case (i)
            0:       return 16'h3103;
            1:       return 16'h3008;
            2:       return 16'h3017;
            default: return 16'h4300;
        endcase
    endfunction

    function automatic logic [7:0] data_of(input int i);
        case (i)
            0:       return 8'h11;
            1:       return 8'h82;
            2:       return 8'hFF;
            default: return 8'h6F;
        endcase
    endfunction

    function automatic logic [23:0] rom_entry(input int i);
        return {addr_of(i), data_of(i)};
    endfunction

    // Synchronous ROM, one cycle of read latency
    always @(posedge clk)
        rom_data <= (rom_addr < 8'(REG_NUM)) ? rom_entry(int'(rom_addr)) : 24'h0;

    // SCCB master model: done 8 cycles after req, NACKs the first nack_plan[i] attempts of entry i
    int nack_plan[REG_NUM];
    int attempts[REG_NUM];
    logic [23:0] log_q[$];
    int m_cnt;

    function automatic logic model_nack(input logic [15:0] a);
        for (int i = 0; i < int'(REG_NUM); i++)
            if (addr_of(i) == a && attempts[i] < nack_plan[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt         <= 0;
            bus.sccb_done <= 1'b0;
            bus.sccb_nack <= 1'b0;
            log_q.delete();
            for (int i = 0; i < int'(REG_NUM); i++) attempts[i] <= 0;
        end else begin
            bus.sccb_done <= 1'b0;
            bus.sccb_nack <= 1'b0;
            if (bus.sccb_req && !bus.sccb_done) begin
                if (m_cnt == 0) log_q.push_back({bus.sccb_addr, bus.sccb_wdata});
                if (m_cnt == 7) begin
                    bus.sccb_done <= 1'b1;
                    bus.sccb_nack <= model_nack(bus.sccb_addr);
                    for (int i = 0; i < int'(REG_NUM); i++)
                        if (addr_of(i) == bus.sccb_addr) attempts[i] <= attempts[i] + 1;
                    m_cnt <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    task automatic do_reset();
        cfg_start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
        nack_plan[0] = p0;
        nack_plan[1] = p1;
        nack_plan[2] = p2;
        nack_plan[3] = p3;
    endtask

    // Waits for cfg_done or cfg_err; returns 0 if the budget expires
    task automatic wait_end(output bit ok);
        int cyc = 0;
        while (!cfg_done && !cfg_err && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        ok = cfg_done || cfg_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({cam_pwdn, cam_reset, bus.sccb_req, cfg_done, cfg_err, cfg_busy} !== 6'b100001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 100001", {cam_pwdn, cam_reset, bus.sccb_req, cfg_done, cfg_err, cfg_busy});
        end
        n_tests++;
        if ({rom_addr, bus.sccb_addr, bus.sccb_wdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h expected 0", {rom_addr, bus.sccb_addr, bus.sccb_wdata});
        end
    endtask

    task automatic test_powerup();
        int cyc;
        set_plan(0, 0, 0, 0);
        do_reset();
        cyc = 0;
        while (cam_pwdn && cyc < 200) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc < 49 || cyc > 51) begin
            n_fail++;
            $display("FAIL pwdn_fall: got %0d cycles expected 50", cyc);
        end
        cyc = 0;
        while (!cam_reset && cyc < 200) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc != 10) begin
            n_fail++;
            $display("FAIL reset_rise: got %0d cycles expected 10", cyc);
        end
        cyc = 0;
        while (!bus.sccb_req && cyc < 400) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc != 202) begin
            n_fail++;
            $display("FAIL first_req: got %0d cycles expected 202", cyc);
        end
        n_tests++;
        if ({bus.sccb_addr, bus.sccb_wdata} !== rom_entry(0)) begin
            n_fail++;
            $display("FAIL first_req_data: got %h expected %h", {bus.sccb_addr, bus.sccb_wdata}, rom_entry(0));
        end
    endtask

    task automatic test_full_table();
        bit ok;
        set_plan(0, 0, 0, 0);
        do_reset();
        wait_end(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL full_timeout: got no end expected cfg_done"); end
        n_tests++;
        if (log_q.size() != 4) begin
            n_fail++;
            $display("FAIL full_count: got %0d writes expected 4", log_q.size());
        end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            n_tests++;
            if (log_q[i] !== rom_entry(i)) begin
                n_fail++;
                $display("FAIL full_write%0d: got %h expected %h", i, log_q[i], rom_entry(i));
            end
        end
        n_tests++;
        if ({cfg_done, cfg_err, cfg_busy, cam_pwdn, cam_reset} !== 5'b10001 || rom_addr !== 8'd3) begin
            n_fail++;
            $display("FAIL full_status: got %b addr %0d expected 10001 addr 3",
                     {cfg_done, cfg_err, cfg_busy, cam_pwdn, cam_reset}, rom_addr);
        end
    endtask

    task automatic test_nack_retry();
        bit ok;
        int exp_idx[6] = '{0, 1, 2, 2, 2, 3};
        set_plan(0, 0, 2, 0);
        do_reset();
        wait_end(ok);
        n_tests++;
        if (!ok || log_q.size() != 6) begin
            n_fail++;
            $display("FAIL retry_count: got %0d writes expected 6", log_q.size());
        end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            n_tests++;
            if (log_q[i] !== rom_entry(exp_idx[i])) begin
                n_fail++;
                $display("FAIL retry_write%0d: got %h expected %h", i, log_q[i], rom_entry(exp_idx[i]));
            end
        end
        n_tests++;
        if ({cfg_done, cfg_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL retry_done: got %b expected 10", {cfg_done, cfg_err});
        end
    endtask

    task automatic test_nack_fail();
        bit ok;
        set_plan(0, 4, 0, 0);
        do_reset();
        wait_end(ok);
        repeat (100) @(negedge clk);
        n_tests++;
        if ({cfg_done, cfg_err, cfg_busy} !== 3'b010 || rom_addr !== 8'd1) begin
            n_fail++;
            $display("FAIL err_status: got %b addr %0d expected 010 addr 1", {cfg_done, cfg_err, cfg_busy}, rom_addr);
        end
        n_tests++;
        if (log_q.size() != 5 || bus.sccb_req !== 1'b0) begin
            n_fail++;
            $display("FAIL err_attempts: got %0d writes req %b expected 5 req 0", log_q.size(), bus.sccb_req);
        end
    endtask

    task automatic test_cfg_start();
        bit ok;
        int cyc = 0;
        set_plan(0, 0, 0, 0);
        do_reset();
        while (!cam_reset && cyc < 200) begin @(negedge clk); cyc++; end
        @(negedge clk); cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        n_tests++;
        if ({cam_pwdn, cam_reset, cfg_busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL start_in_init: got %b expected 011", {cam_pwdn, cam_reset, cfg_busy});
        end
        wait_end(ok);
        n_tests++;
        if (!cfg_done || log_q.size() != 4) begin
            n_fail++;
            $display("FAIL start_first_run: got done %b writes %0d expected 1 and 4", cfg_done, log_q.size());
        end
        @(negedge clk); cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        n_tests++;
        if ({cam_pwdn, cam_reset, cfg_done, cfg_busy} !== 4'b1001 || rom_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL start_in_done: got %b addr %0d expected 1001 addr 0",
                     {cam_pwdn, cam_reset, cfg_done, cfg_busy}, rom_addr);
        end
        wait_end(ok);
        n_tests++;
        if (!cfg_done || log_q.size() != 8) begin
            n_fail++;
            $display("FAIL start_rerun: got done %b writes %0d expected 1 and 8", cfg_done, log_q.size());
        end
        for (int i = 4; i < 8 && i < log_q.size(); i++) begin
            n_tests++;
            if (log_q[i] !== rom_entry(i - 4)) begin
                n_fail++;
                $display("FAIL rerun_write%0d: got %h expected %h", i, log_q[i], rom_entry(i - 4));
            end
        end
    endtask

    task automatic test_rst_mid_transfer();
        bit ok;
        int cyc = 0;
        set_plan(0, 0, 0, 0);
        do_reset();
        while (!bus.sccb_req && cyc < 400) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.sccb_req, cam_pwdn, cam_reset, cfg_busy} !== 4'b0101) begin
            n_fail++;
            $display("FAIL rst_async: got %b expected 0101", {bus.sccb_req, cam_pwdn, cam_reset, cfg_busy});
        end
        @(negedge clk); rst = 1'b0;
        cyc = 0;
        while (cam_pwdn && cyc < 200) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (cyc < 49 || cyc > 51) begin
            n_fail++;
            $display("FAIL rst_restart_pwdn: got %0d cycles expected 50", cyc);
        end
        wait_end(ok);
        n_tests++;
        if (!cfg_done || log_q.size() != 4) begin
            n_fail++;
            $display("FAIL rst_restart_run: got done %b writes %0d expected 1 and 4", cfg_done, log_q.size());
        end
    endtask

    initial begin
        set_plan(0, 0, 0, 0);
        test_reset();
        test_powerup();
        test_full_table();
        test_nack_retry();
        test_nack_fail();
        test_cfg_start();
        test_rst_mid_transfer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
